// File: rtl/mem_arbiter.sv
// Purpose : shares one unified Memory port between instruction fetch and load/store, one access at a time.
// Latency : request sampled at IDLE edge k, memory driven k..k+1, ack pulse k+1..k+2, next sample at k+3.
// Backpressure: requesters hold their request until ack; mem_ack_i=0 stretches ACCESS indefinitely.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_rd_en_i, i_addr_i           instruction read request / address
//   i_data_o, i_ack_o             instruction read data (held) / one-cycle completion pulse
//   d_rd_en_i, d_wr_en_i          data read / write request (write wins if both set)
//   d_addr_i, d_data_i            data address / write data
//   d_data_o, d_ack_o             load data (held) / one-cycle completion pulse
//   mem_rd_en_o, mem_wr_en_o      Memory read / write enables
//   mem_addr_o, mem_data_o        Memory address / write data
//   mem_data_i, mem_ack_i         Memory read data / access-complete strobe
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rd_en_i,
    input  logic [31:0] i_addr_i,
    output logic [31:0] i_data_o,
    output logic        i_ack_o,
    input  logic        d_rd_en_i,
    input  logic        d_wr_en_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    output logic [31:0] d_data_o,
    output logic        d_ack_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t      state_q;
    owner_t      owner_q;
    logic        op_wr_q;
    logic [3:0]  starve_cnt_q;
    logic [3:0]  starve_cnt_d;
    logic [31:0] i_data_q;
    logic [31:0] d_data_q;
    logic        i_ack_q;
    logic        d_ack_q;
    // The mem_* registers double as the latched address / write data of the
    // access in flight; they are zero outside ACCESS.
    logic        mem_rd_en_q;
    logic        mem_wr_en_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;

    logic d_req;
    logic grant_i;
    logic grant_d;

    // Data-first arbitration; instruction wins only once the data side has
    // taken STARVE_LIMIT consecutive grants over a pending fetch.
    always_comb begin
        d_req        = d_rd_en_i | d_wr_en_i;
        grant_i      = i_rd_en_i && (!d_req || (starve_cnt_q == LIMIT));
        grant_d      = d_req && !grant_i;
        starve_cnt_d = starve_cnt_q;
        if (!i_rd_en_i || grant_i) begin
            starve_cnt_d = 4'd0;
        end else if (grant_d && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            op_wr_q      <= 1'b0;
            starve_cnt_q <= 4'd0;
            i_data_q     <= 32'd0;
            d_data_q     <= 32'd0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_data_q   <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    starve_cnt_q <= starve_cnt_d;
                    if (grant_i) begin
                        owner_q     <= OWN_I;
                        op_wr_q     <= 1'b0;
                        mem_rd_en_q <= 1'b1;
                        mem_wr_en_q <= 1'b0;
                        mem_addr_q  <= i_addr_i;
                        mem_data_q  <= 32'd0;
                        state_q     <= S_ACCESS;
                    end else if (grant_d) begin
                        // A simultaneous read+write request is a write.
                        owner_q     <= OWN_D;
                        op_wr_q     <= d_wr_en_i;
                        mem_rd_en_q <= !d_wr_en_i;
                        mem_wr_en_q <= d_wr_en_i;
                        mem_addr_q  <= d_addr_i;
                        mem_data_q  <= d_wr_en_i ? d_data_i : 32'd0;
                        state_q     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Without mem_ack_i all drives simply hold (wait state).
                    if (mem_ack_i) begin
                        if (!op_wr_q) begin
                            if (owner_q == OWN_I) begin
                                i_data_q <= mem_data_i;
                            end else begin
                                d_data_q <= mem_data_i;
                            end
                        end
                        i_ack_q     <= (owner_q == OWN_I);
                        d_ack_q     <= (owner_q == OWN_D);
                        mem_rd_en_q <= 1'b0;
                        mem_wr_en_q <= 1'b0;
                        mem_addr_q  <= 32'd0;
                        mem_data_q  <= 32'd0;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    owner_q <= OWN_NONE;
                    op_wr_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign i_data_o    = i_data_q;
    assign i_ack_o     = i_ack_q;
    assign d_data_o    = d_data_q;
    assign d_ack_o     = d_ack_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_rd_en_i;
    logic [31:0] i_addr_i;
    logic [31:0] i_data_o;
    logic        i_ack_o;
    logic        d_rd_en_i;
    logic        d_wr_en_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_data_i;
    logic [31:0] d_data_o;
    logic        d_ack_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    int vectors;
    int miscompares;

    // Memory model: word-addressed, answers in the same cycle unless stalled.
    logic [31:0] mem [0:63];
    logic        mem_stall;
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    assign mem_ack_i  = (mem_rd_en_o | mem_wr_en_o) && !mem_stall;
    assign mem_data_i = mem_rd_en_o ? mem[mem_addr_o[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (mem_wr_en_o && mem_ack_i) begin
            mem[mem_addr_o[7:2]] <= mem_data_o;
        end
    end

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_en_i   (i_rd_en_i),
        .i_addr_i    (i_addr_i),
        .i_data_o    (i_data_o),
        .i_ack_o     (i_ack_o),
        .d_rd_en_i   (d_rd_en_i),
        .d_wr_en_i   (d_wr_en_i),
        .d_addr_i    (d_addr_i),
        .d_data_i    (d_data_i),
        .d_data_o    (d_data_o),
        .d_ack_o     (d_ack_o),
        .mem_rd_en_o (mem_rd_en_o),
        .mem_wr_en_o (mem_wr_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Bounded wait for either ack, sampled at negedges.
    task automatic wait_ack(output logic got_i, output logic got_d, output logic timeout);
        got_i   = 1'b0;
        got_d   = 1'b0;
        timeout = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (i_ack_o || d_ack_o) begin
                got_i   = i_ack_o;
                got_d   = d_ack_o;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({i_ack_o, d_ack_o} !== 2'b00) begin
            miscompares++; $display("FAIL reset_acks got %b want 00", {i_ack_o, d_ack_o});
        end
        vectors++;
        if ({mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o} !== 66'd0) begin
            miscompares++; $display("FAIL reset_mem got %h want 0", {mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o});
        end
        vectors++;
        if ({i_data_o, d_data_o} !== 64'd0) begin
            miscompares++; $display("FAIL reset_data got %h want 0", {i_data_o, d_data_o});
        end
        preload(6'd4, 32'hDEADBEEF);
        preload(6'd12, 32'hCAFEF00D);
        preload(6'd16, 32'h11111111);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ifetch();
        @(negedge clk);
        i_rd_en_i = 1'b1;
        i_addr_i  = 32'h10;
        @(negedge clk);
        vectors++;
        if ({mem_rd_en_o, mem_wr_en_o, mem_addr_o} !== {2'b10, 32'h10}) begin
            miscompares++; $display("FAIL ifetch_drive got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=10", mem_rd_en_o, mem_wr_en_o, mem_addr_o);
        end
        @(negedge clk);
        vectors++;
        if ({i_ack_o, d_ack_o, i_data_o} !== {2'b10, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL ifetch_ack got i_ack=%b d_ack=%b data=%h want 1 0 deadbeef", i_ack_o, d_ack_o, i_data_o);
        end
        vectors++;
        if (mem_rd_en_o !== 1'b0) begin
            miscompares++; $display("FAIL ifetch_resp_mem got rd=%b want 0", mem_rd_en_o);
        end
        i_rd_en_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({i_ack_o, i_data_o} !== {1'b0, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL ifetch_pulse got ack=%b data=%h want 0 deadbeef", i_ack_o, i_data_o);
        end
    endtask

    task automatic test_priority();
        logic gi, gd, to;
        @(negedge clk);
        i_rd_en_i = 1'b1;
        i_addr_i  = 32'h10;
        d_wr_en_i = 1'b1;
        d_addr_i  = 32'h20;
        d_data_i  = 32'h12345678;
        @(negedge clk);
        vectors++;
        if ({mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o} !== {2'b01, 32'h20, 32'h12345678}) begin
            miscompares++; $display("FAIL prio_write_drive got rd=%b wr=%b addr=%h data=%h want 0 1 20 12345678", mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o);
        end
        @(negedge clk);
        vectors++;
        if ({i_ack_o, d_ack_o} !== 2'b01) begin
            miscompares++; $display("FAIL prio_d_ack got i=%b d=%b want 0 1", i_ack_o, d_ack_o);
        end
        d_wr_en_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({d_ack_o, mem_rd_en_o} !== 2'b00) begin
            miscompares++; $display("FAIL prio_idle got d_ack=%b rd=%b want 0 0", d_ack_o, mem_rd_en_o);
        end
        @(negedge clk);
        vectors++;
        if ({mem_rd_en_o, mem_addr_o} !== {1'b1, 32'h10}) begin
            miscompares++; $display("FAIL prio_i_follows got rd=%b addr=%h want 1 10", mem_rd_en_o, mem_addr_o);
        end
        @(negedge clk);
        vectors++;
        if ({i_ack_o, i_data_o} !== {1'b1, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL prio_i_ack got ack=%b data=%h want 1 deadbeef", i_ack_o, i_data_o);
        end
        i_rd_en_i = 1'b0;
        d_rd_en_i = 1'b1;
        d_addr_i  = 32'h20;
        wait_ack(gi, gd, to);
        d_rd_en_i = 1'b0;
        vectors++;
        if (to || !gd || d_data_o !== 32'h12345678) begin
            miscompares++; $display("FAIL prio_readback got timeout=%b d_ack=%b data=%h want 0 1 12345678", to, gd, d_data_o);
        end
    endtask

    task automatic test_starvation();
        logic       gi, gd, to;
        logic [9:0] exp_i;
        exp_i = 10'b10000_10000; // bit n set => grant n is instruction (grants 4 and 9)
        @(negedge clk);
        i_rd_en_i = 1'b1;
        i_addr_i  = 32'h10;
        d_rd_en_i = 1'b1;
        d_addr_i  = 32'h20;
        for (int n = 0; n < 10; n++) begin
            wait_ack(gi, gd, to);
            vectors++;
            if (to || gi !== exp_i[n] || gd !== !exp_i[n]) begin
                miscompares++; $display("FAIL starve_grant%0d got timeout=%b i=%b d=%b want i=%b", n, to, gi, gd, exp_i[n]);
            end
            if (to) break;
        end
        i_rd_en_i = 1'b0;
        d_rd_en_i = 1'b0;
        vectors++;
        if ({i_data_o, d_data_o} !== {32'hDEADBEEF, 32'h12345678}) begin
            miscompares++; $display("FAIL starve_data got i=%h d=%h want deadbeef 12345678", i_data_o, d_data_o);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        int acks;
        mem_stall = 1'b1;
        d_rd_en_i = 1'b1;
        d_addr_i  = 32'h30;
        acks      = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            vectors++;
            if ({mem_rd_en_o, mem_wr_en_o, mem_addr_o, d_ack_o} !== {2'b10, 32'h30, 1'b0}) begin
                miscompares++; $display("FAIL wait_hold%0d got rd=%b wr=%b addr=%h ack=%b want 1 0 30 0", n, mem_rd_en_o, mem_wr_en_o, mem_addr_o, d_ack_o);
            end
        end
        mem_stall = 1'b0;
        @(negedge clk);
        vectors++;
        if ({d_ack_o, d_data_o} !== {1'b1, 32'hCAFEF00D}) begin
            miscompares++; $display("FAIL wait_ack got ack=%b data=%h want 1 cafef00d", d_ack_o, d_data_o);
        end
        d_rd_en_i = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (d_ack_o) acks++;
        end
        vectors++;
        if (acks != 0) begin
            miscompares++; $display("FAIL wait_single_ack got %0d extra acks want 0", acks);
        end
    endtask

    task automatic test_reset_mid_access();
        int acks;
        acks      = 0;
        d_wr_en_i = 1'b1;
        d_addr_i  = 32'h40;
        d_data_i  = 32'h55555555;
        @(negedge clk);
        vectors++;
        if (mem_wr_en_o !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_pre got wr=%b want 1", mem_wr_en_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o, i_ack_o, d_ack_o, i_data_o, d_data_o} !== 132'd0) begin
            miscompares++; $display("FAIL rst_mid_outputs got wr=%b addr=%h i_data=%h d_data=%h want all 0", mem_wr_en_o, mem_addr_o, i_data_o, d_data_o);
        end
        d_wr_en_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (i_ack_o || d_ack_o) acks++;
        end
        vectors++;
        if (acks != 0) begin
            miscompares++; $display("FAIL rst_mid_no_ack got %0d acks want 0", acks);
        end
        vectors++;
        if (mem[16] !== 32'h11111111) begin
            miscompares++; $display("FAIL rst_mid_mem got %h want 11111111", mem[16]);
        end
    endtask

    task automatic test_rdwr_combined();
        logic gi, gd, to;
        d_rd_en_i = 1'b1;
        d_addr_i  = 32'h30;
        wait_ack(gi, gd, to);
        d_rd_en_i = 1'b0;
        vectors++;
        if (to || d_data_o !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL rdwr_setup got timeout=%b data=%h want 0 cafef00d", to, d_data_o);
        end
        @(negedge clk);
        d_rd_en_i = 1'b1;
        d_wr_en_i = 1'b1;
        d_addr_i  = 32'h44;
        d_data_i  = 32'hA5A5A5A5;
        @(negedge clk);
        vectors++;
        if ({mem_rd_en_o, mem_wr_en_o, mem_data_o} !== {2'b01, 32'hA5A5A5A5}) begin
            miscompares++; $display("FAIL rdwr_is_write got rd=%b wr=%b data=%h want 0 1 a5a5a5a5", mem_rd_en_o, mem_wr_en_o, mem_data_o);
        end
        @(negedge clk);
        vectors++;
        if ({d_ack_o, d_data_o} !== {1'b1, 32'hCAFEF00D}) begin
            miscompares++; $display("FAIL rdwr_ack got ack=%b data=%h want 1 cafef00d", d_ack_o, d_data_o);
        end
        d_rd_en_i = 1'b0;
        d_wr_en_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (d_ack_o !== 1'b0 || mem[17] !== 32'hA5A5A5A5) begin
            miscompares++; $display("FAIL rdwr_done got ack=%b mem=%h want 0 a5a5a5a5", d_ack_o, mem[17]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        i_rd_en_i   = 1'b0;
        i_addr_i    = 32'd0;
        d_rd_en_i   = 1'b0;
        d_wr_en_i   = 1'b0;
        d_addr_i    = 32'd0;
        d_data_i    = 32'd0;
        mem_stall   = 1'b0;
        pl_en       = 1'b0;
        pl_idx      = 6'd0;
        pl_val      = 32'd0;
        test_reset();
        test_ifetch();
        test_priority();
        test_starvation();
        test_wait_states();
        test_reset_mid_access();
        test_rdwr_combined();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified `Memory` port between the instruction-fetch unit and the load/store unit of the datapath.
- Accepts held-request transactions from both sides and runs one memory access at a time.
- Picks a winner using data-first priority, bounded so instruction fetch cannot starve.
- Returns read data from a response register, with a one-cycle ack pulse to the winner.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while an instruction request is pending; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_rd_en_i  in  1  instruction read request; held until i_ack_o is seen.
- i_addr_i  in  32  instruction address.
- i_data_o  out  32  instruction read data; valid while i_ack_o=1, held afterwards.
- i_ack_o  out  1  one-cycle completion pulse for the instruction port.
- d_rd_en_i  in  1  data read request; held until d_ack_o is seen.
- d_wr_en_i  in  1  data write request; held until d_ack_o is seen.
- d_addr_i  in  32  data address.
- d_data_i  in  32  write data.
- d_data_o  out  32  load data; valid while d_ack_o=1, held afterwards.
- d_ack_o  out  1  one-cycle completion pulse for the data port.
- mem_rd_en_o  out  1  to Memory rd_en_i.
- mem_wr_en_o  out  1  to Memory wr_en_i.
- mem_addr_o  out  32  to Memory addr_i.
- mem_data_o  out  32  to Memory data_i.
- mem_data_i  in  32  from Memory data_o.
- mem_ack_i  in  1  from Memory ack_o; 1 = access complete this cycle.

Behaviour:
- Reset:
  - rst_n=0 forces, immediately and asynchronously: state IDLE, all outputs 0, latched addr/data/op 0, starvation counter 0, owner=none.
  - Reset mid-access aborts the access: no ack, mem_wr_en_o drops at once, no further write is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only at edges while in IDLE; ACCESS and RESP ignore the request inputs.
  - With no request pending, stay in IDLE.
  - Otherwise choose the winner, latch its addr, write data and op (read or write), set owner, and go to ACCESS.
- Arbitration:
  - Data wins unless the instruction port is requesting and starve_cnt==STARVE_LIMIT; in that case instruction wins.
  - A data grant with i_rd_en_i=1 increments starve_cnt, saturating at STARVE_LIMIT.
  - An instruction grant, or any IDLE edge with i_rd_en_i=0, clears starve_cnt.
- Data op decode:
  - d_wr_en_i=1 means write, even if d_rd_en_i=1 at the same time.
  - d_rd_en_i=1 alone means read.
- ACCESS:
  - mem_addr_o = latched address.
  - mem_rd_en_o=1 for a read; mem_wr_en_o=1 and mem_data_o = latched data for a write.
  - Edge with mem_ack_i=1: for a read, load mem_data_i into the owner's response register; go to RESP.
  - Edge with mem_ack_i=0: stay in ACCESS with all drives unchanged (wait states are legal; repeated writes of identical data are acceptable).
- RESP:
  - All mem_* outputs are 0.
  - The owner's ack_o=1 for exactly one cycle; the other port's ack stays 0.
  - Always go to IDLE at the next edge.
- Response data: a write does not change d_data_o. Response registers hold their value until the next read by the same port.
- Latency:
  - Request sampled at IDLE edge k; with mem_ack_i=1, ack is high between edges k+1 and k+2.
  - The next sample is at edge k+3, so the minimum is one access per 3 cycles.
- Requester rule: deassert the request (or present a new one) in the cycle after ack is sampled. A request still high at edge k+3 is treated as a new access.
- Outside ACCESS, mem_rd_en_o=0, so Memory drives z; the arbiter never samples mem_data_i outside ACCESS.
- All outputs are registered or decoded from state/latches only; there is no combinational path from request inputs to outputs.

Test Plan:
- Reset, then i_rd_en_i=1, i_addr_i=0x10 with mem word 4 = 0xDEADBEEF.
  - mem_rd_en_o=1, mem_addr_o=0x10 in the cycle after the sample edge.
  - i_ack_o=1, i_data_o=0xDEADBEEF one cycle later.
  - d_ack_o stays 0.
- i_rd_en_i and d_wr_en_i (addr 0x20, data 0x12345678) both asserted at one edge.
  - Data is granted first: mem_wr_en_o=1, mem_data_o=0x12345678, then d_ack_o.
  - The instruction access follows.
  - A later read of 0x20 returns 0x12345678.
- Data and instruction requests held continuously, STARVE_LIMIT=4: the grant sequence is D,D,D,D,I,D,D,D,D,I.
- Hold mem_ack_i=0 for 3 cycles during a data read of 0x30: state stays ACCESS with drives stable; d_ack_o asserts exactly once, one cycle after mem_ack_i returns to 1.
- Pull rst_n low while in ACCESS for a write to 0x40: all outputs go 0 immediately, no ack follows, and memory 0x40 is unchanged if reset lands before the write edge.
- d_rd_en_i=1 and d_wr_en_i=1 together with d_data_i=0xA5A5A5A5: treated as a write; d_data_o keeps its previous value and d_ack_o pulses once.
